// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a word-addressed RAM with byte strobes, independent
// read/write FSMs, programmable read latency and SLVERR for out-of-range addresses.
module axi_lite_mem_slave #(
  parameter int    ADDR_WIDTH   = 32,
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH_WORDS  = 1024,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY,
  output logic [1:0]                o_dbg_w_state,
  output logic [1:0]                o_dbg_r_state
);

  // Handshake rule for every channel: a beat transfers on a rising edge where VALID and
  // READY are both 1; our VALIDs hold (with stable payload) until that edge, and all our
  // READY/VALID outputs are registered so none depends combinationally on the master.

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_HAVE_AW = 2'd1, W_HAVE_W = 2'd2, W_RESP = 2'd3} w_state_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  function automatic logic f_oor(input logic [ADDR_WIDTH-1:0] a);
    return a >= ADDR_WIDTH'(4 * DEPTH_WORDS);
  endfunction

  // ---------------- write channel ----------------
  w_state_t              r_w_state, w_w_state_next;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  w_aw_hs, w_w_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]     w_wstrb;
  logic [IDX_W-1:0]      w_widx;

  assign w_aw_hs = AWVALID & r_awready;
  assign w_w_hs  = WVALID & r_wready;
  // The beat completing on this edge is used directly; the earlier one comes from its latch.
  assign w_waddr = w_aw_hs ? AWADDR : r_awaddr;
  assign w_wdata = w_w_hs ? WDATA : r_wdata;
  assign w_wstrb = w_w_hs ? WSTRB : r_wstrb;
  assign w_widx  = w_waddr[IDX_W+1:2];

  always_comb begin
    w_w_state_next = r_w_state;
    w_commit       = 1'b0;
    case (r_w_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) begin
          w_w_state_next = W_RESP;
          w_commit       = 1'b1;
        end else if (w_aw_hs) begin
          w_w_state_next = W_HAVE_AW;
        end else if (w_w_hs) begin
          w_w_state_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: if (w_w_hs) begin
        w_w_state_next = W_RESP;
        w_commit       = 1'b1;
      end
      W_HAVE_W: if (w_aw_hs) begin
        w_w_state_next = W_RESP;
        w_commit       = 1'b1;
      end
      W_RESP: if (BREADY) w_w_state_next = W_IDLE;
      default: w_w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_w_state <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_w_state <= w_w_state_next;
      r_awready <= (w_w_state_next == W_IDLE) || (w_w_state_next == W_HAVE_W);
      r_wready  <= (w_w_state_next == W_IDLE) || (w_w_state_next == W_HAVE_AW);
      r_bvalid  <= (w_w_state_next == W_RESP);
      if (w_commit) r_bresp <= f_oor(w_waddr) ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_aw_hs) r_awaddr <= AWADDR;
    if (w_w_hs) begin
      r_wdata <= WDATA;
      r_wstrb <= WSTRB;
    end
  end

  // RAM is not reset; a commit coinciding with a reset edge is dropped.
  always_ff @(posedge ACLK) begin
    if (ARESETN && w_commit && !f_oor(w_waddr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_wstrb[i]) r_mem[w_widx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              r_r_state, w_r_state_next;
  logic                  r_arready, r_rvalid, r_ar_oor;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [IDX_W-1:0]      r_ridx;
  logic [3:0]            r_rcnt;
  logic                  w_ar_hs, w_rsample;

  assign w_ar_hs = ARVALID & r_arready;

  always_comb begin
    w_r_state_next = r_r_state;
    w_rsample      = 1'b0;
    case (r_r_state)
      R_IDLE: if (w_ar_hs) w_r_state_next = R_WAIT;
      R_WAIT: if (r_rcnt == 4'd0) begin
        w_r_state_next = R_RESP;
        w_rsample      = 1'b1;
      end
      R_RESP: if (RREADY) w_r_state_next = R_IDLE;
      default: w_r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_r_state <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
      r_rcnt    <= 4'd0;
      r_ridx    <= '0;
      r_ar_oor  <= 1'b0;
    end else begin
      r_r_state <= w_r_state_next;
      r_arready <= (w_r_state_next == R_IDLE);
      r_rvalid  <= (w_r_state_next == R_RESP);
      if (w_ar_hs) begin
        r_ridx   <= ARADDR[IDX_W+1:2];
        r_ar_oor <= f_oor(ARADDR);
        r_rcnt   <= 4'(READ_LATENCY - 1);
      end else if (r_r_state == R_WAIT && r_rcnt != 4'd0) begin
        r_rcnt <= r_rcnt - 4'd1;
      end
      // Sampling with a non-blocking read gives pre-write data for a same-edge commit.
      if (w_rsample) begin
        r_rdata <= r_ar_oor ? '0 : r_mem[r_ridx];
        r_rresp <= r_ar_oor ? 2'b10 : 2'b00;
      end
    end
  end

  assign AWREADY       = r_awready;
  assign WREADY        = r_wready;
  assign BVALID        = r_bvalid;
  assign BRESP         = r_bresp;
  assign ARREADY       = r_arready;
  assign RVALID        = r_rvalid;
  assign RRESP         = r_rresp;
  assign RDATA         = r_rdata;
  assign o_dbg_w_state = r_w_state;
  assign o_dbg_r_state = r_r_state;

endmodule
